// File: rtl/jtdd_sndcmd.sv
// Sound command mailbox between the main CPU and the sound CPU.
// 4-deep command FIFO, IRQ strobe with ack/timeout, and sound CPU reset control.
module jtdd_sndcmd #(
    parameter int IRQ_W   = 8,
    parameter int ACK_TO  = 4096,
    parameter int RST_MIN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_cen,
    input  logic [7:0] cpu_dout,
    input  logic       cmd_we,
    input  logic       rstctl_we,
    input  logic       snd_ack,
    output logic [7:0] snd_latch,
    output logic       snd_irq,
    output logic       snd_rstb,
    output logic       busy,
    output logic       full,
    output logic [2:0] level,
    output logic       ovf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PULSE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam int IW = $clog2(IRQ_W + 1);
    localparam int TW = $clog2(ACK_TO + 1);
    localparam int RW = $clog2(RST_MIN + 1);

    logic [7:0]    mem [4];
    logic [1:0]    wr_ptr, rd_ptr;
    logic [1:0]    state;
    logic [IW-1:0] irq_cnt;
    logic [TW-1:0] to_cnt;
    logic [RW-1:0] rst_cnt;
    logic          ack_prev, ack_seen, rel_pend;

    logic cmd_wr, flush, release_wr, ack_rise;
    logic pop, push, rst_done;

    always_comb begin
        cmd_wr     = cmd_we & cpu_cen;
        flush      = rstctl_we & cpu_cen & ~cpu_dout[0];
        release_wr = rstctl_we & cpu_cen & cpu_dout[0];
        ack_rise   = snd_ack & ~ack_prev;
        full       = level == 3'd4;
        busy       = (level != 3'd0) || (state != IDLE);
        pop        = (state == IDLE) && (level != 3'd0)
                     && snd_rstb && !flush;
        // a full FIFO still takes a write when the head leaves this cycle
        push       = cmd_wr && !flush && (!full || pop);
        rst_done   = rst_cnt >= RW'(RST_MIN - 1);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cpu_dout;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            level  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            if (push && !pop)      level <= level + 3'd1;
            else if (pop && !push) level <= level - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            snd_irq   <= 1'b0;
            snd_latch <= 8'h00;
            irq_cnt   <= '0;
            to_cnt    <= '0;
            ack_prev  <= 1'b0;
            ack_seen  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            ack_prev <= snd_ack;
            if (flush) begin
                state    <= IDLE;
                snd_irq  <= 1'b0;
                ack_seen <= 1'b0;
                ovf      <= 1'b0;
            end else begin
                if (cmd_wr && full && !pop) ovf <= 1'b1;
                case (state)
                    IDLE: begin
                        if (pop) begin
                            snd_latch <= mem[rd_ptr];
                            state     <= PULSE;
                            irq_cnt   <= '0;
                            ack_seen  <= 1'b0;
                        end
                    end
                    PULSE: begin
                        if (ack_rise) ack_seen <= 1'b1;
                        // first PULSE cycle keeps irq low, then IRQ_W high cycles
                        if (irq_cnt == IW'(IRQ_W)) begin
                            snd_irq <= 1'b0;
                            to_cnt  <= '0;
                            state   <= (ack_seen || ack_rise) ? IDLE : WAIT;
                        end else begin
                            snd_irq <= 1'b1;
                            irq_cnt <= irq_cnt + 1'b1;
                        end
                    end
                    WAIT: begin
                        if (ack_rise) begin
                            state <= IDLE;
                        end else if (to_cnt == TW'(ACK_TO - 1)) begin
                            ovf   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snd_rstb <= 1'b0;
            rst_cnt  <= '0;
            rel_pend <= 1'b1;
        end else if (flush) begin
            snd_rstb <= 1'b0;
            rst_cnt  <= '0;
            rel_pend <= 1'b0;
        end else if (!snd_rstb) begin
            if (!rst_done) rst_cnt <= rst_cnt + 1'b1;
            // an early release waits here until the minimum low time is met
            if ((rel_pend || release_wr) && rst_done) snd_rstb <= 1'b1;
            else if (release_wr)                       rel_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jtdd_sndcmd.sv
// Randomised and directed bench for jtdd_sndcmd against a queue-based model.
// Model tracks the command by its age since being popped.
module tb_jtdd_sndcmd;

    localparam int IRQ_W   = 8;
    localparam int ACK_TO  = 4096;
    localparam int RST_MIN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_cen = 1'b0;
    logic [7:0] cpu_dout = 8'h00;
    logic       cmd_we = 1'b0;
    logic       rstctl_we = 1'b0;
    logic       snd_ack = 1'b0;
    logic [7:0] snd_latch;
    logic       snd_irq, snd_rstb, busy, full, ovf;
    logic [2:0] level;

    jtdd_sndcmd #(.IRQ_W(IRQ_W), .ACK_TO(ACK_TO), .RST_MIN(RST_MIN)) dut (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .cpu_dout(cpu_dout),
        .cmd_we(cmd_we), .rstctl_we(rstctl_we), .snd_ack(snd_ack),
        .snd_latch(snd_latch), .snd_irq(snd_irq), .snd_rstb(snd_rstb),
        .busy(busy), .full(full), .level(level), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    // behavioural model
    byte unsigned q[$];
    logic [7:0] m_latch;
    bit m_active, m_acked, m_ovf, m_rstb, m_pend, m_prev;
    int m_age, m_low;

    always @(posedge clk) begin
        bit rise, fl, rel, wr, do_pop;
        cyc++;
        rise = snd_ack && !m_prev;
        if (rst) begin
            q.delete();
            m_latch = 8'h00; m_active = 0; m_age = 0; m_acked = 0;
            m_ovf = 0; m_rstb = 0; m_low = 0; m_pend = 1; m_prev = 0;
        end else begin
            fl  = rstctl_we && cpu_cen && !cpu_dout[0];
            rel = rstctl_we && cpu_cen && cpu_dout[0];
            wr  = cmd_we && cpu_cen;
            do_pop = !m_active && q.size() > 0 && m_rstb && !fl;
            if (fl) begin
                q.delete();
                m_active = 0; m_ovf = 0; m_rstb = 0; m_low = 0; m_pend = 0;
            end else begin
                if (m_active) begin
                    if (m_age <= IRQ_W && rise) m_acked = 1;
                    if (m_age == IRQ_W && m_acked) m_active = 0;
                    else if (m_age > IRQ_W && rise) m_active = 0;
                    else if (m_age == IRQ_W + ACK_TO) begin
                        m_ovf = 1; m_active = 0;
                    end else m_age++;
                end
                if (do_pop) begin
                    m_latch = q.pop_front();
                    m_active = 1; m_age = 0; m_acked = 0;
                end
                if (wr) begin
                    if (q.size() < 4) q.push_back(cpu_dout);
                    else m_ovf = 1;
                end
                if (!m_rstb) begin
                    if (rel) m_pend = 1;
                    if (m_pend && m_low + 1 >= RST_MIN) m_rstb = 1;
                    else m_low++;
                end
            end
            m_prev = snd_ack;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("latch", snd_latch, m_latch);
            chk("irq", snd_irq, m_active && m_age >= 1 && m_age <= IRQ_W);
            chk("rstb", snd_rstb, m_rstb);
            chk("level", level, q.size());
            chk("full", full, q.size() == 4);
            chk("busy", busy, q.size() != 0 || m_active);
            chk("ovf", ovf, m_ovf);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cmd(input logic [7:0] d);
        cmd_we = 1; cpu_dout = d; step(); cmd_we = 0;
    endtask

    task automatic wr_rst(input logic b);
        rstctl_we = 1; cpu_dout = {7'd0, b}; step(); rstctl_we = 0;
    endtask

    task automatic wait_irq(input logic v, input int lim);
        int i;
        for (i = 0; i < lim && snd_irq !== v; i++) step();
        if (snd_irq !== v) begin
            n_checks++; n_err++;
            $display("FAIL wait_irq timeout want %0b", v);
        end
    endtask

    task automatic ack_pulse();
        snd_ack = 1; step(); snd_ack = 0;
    endtask

    initial begin
        int lowc, highc, t1, t2;
        logic [7:0] seq [5];
        cpu_cen = 1;
        step();
        rst = 0;
        chk_en = 1;
        chk("rst_rstb", snd_rstb, 0);
        chk("rst_level", level, 0);
        chk("rst_latch", snd_latch, 8'h00);
        chk("rst_busy", busy, 0);
        lowc = 1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (!snd_rstb) lowc++;
        end
        chk("rst_low_len", lowc, 16);

        // single command
        wr_cmd(8'h3C);
        step();
        chk("single_latch", snd_latch, 8'h3C);
        highc = 0;
        for (int i = 0; i < 19; i++) begin
            if (snd_irq) highc++;
            step();
        end
        chk("single_irq_w", highc, 8);
        ack_pulse();
        chk("single_busy", busy, 0);

        // burst with overflow
        for (int i = 1; i <= 5; i++) wr_cmd(8'(i));
        chk("burst_level", level, 4);
        chk("burst_full", full, 1);
        wr_cmd(8'h06);
        chk("burst_ovf", ovf, 1);
        for (int k = 0; k < 5; k++) begin
            wait_irq(1, 200);
            seq[k] = snd_latch;
            ack_pulse();
            wait_irq(0, 50);
        end
        for (int i = 0; i < 50 && busy; i++) step();
        for (int k = 0; k < 5; k++) chk("burst_seq", seq[k], k + 1);
        chk("burst_idle", busy, 0);

        // push+pop while full, then spacing with early ack
        wr_rst(0);
        for (int i = 0; i < 4; i++) wr_cmd(8'h10 + 8'(i));
        wr_rst(1);
        for (int i = 0; i < 40 && !snd_rstb; i++) step();
        chk("pp_full_pre", full, 1);
        wr_cmd(8'h20);
        chk("pp_level", level, 4);
        chk("pp_ovf", ovf, 0);
        wait_irq(1, 20);
        t1 = cyc;
        ack_pulse();
        wait_irq(0, 20);
        wait_irq(1, 20);
        t2 = cyc;
        chk("irq_spacing", t2 - t1, 10);
        chk("q3_level", level, 3);

        // reset control with 3 entries queued
        wr_rst(0);
        chk("flush_level", level, 0);
        chk("flush_irq", snd_irq, 0);
        lowc = 1;
        step();
        if (!snd_rstb) lowc++;
        wr_rst(1);
        if (!snd_rstb) lowc++;
        highc = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!snd_rstb) lowc++;
            if (snd_irq) highc++;
        end
        chk("flush_low_len", lowc, 16);
        chk("flush_no_irq", highc, 0);

        // ack timeout
        wr_cmd(8'hAA);
        wr_cmd(8'hBB);
        wait_irq(1, 20);
        chk("to_first", snd_latch, 8'hAA);
        chk("to_ovf_pre", ovf, 0);
        wait_irq(0, 20);
        wait_irq(1, ACK_TO + 100);
        chk("to_latch", snd_latch, 8'hBB);
        chk("to_ovf", ovf, 1);
        wr_rst(0);
        wr_rst(1);

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            cpu_cen   = ($urandom % 4) != 0;
            cmd_we    = ($urandom % 3) == 0;
            rstctl_we = ($urandom % 250) == 0;
            cpu_dout  = 8'($urandom);
            if (rstctl_we) cpu_dout[0] = ($urandom % 3) != 0;
            snd_ack   = ($urandom % 6) == 0;
            rst       = ($urandom % 2000) == 0;
            step();
        end
        cmd_we = 0; rstctl_we = 0; snd_ack = 0; rst = 0;
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/jtdd_sndcmd.md
JTDD_SNDCMD -- requirements
Module: jtdd_sndcmd

Interface
REQ-001 Parameter IRQ_W, default 8: clk cycles that snd_irq stays high per command.
REQ-002 Parameter ACK_TO, default 4096: clk cycles to wait for an acknowledge before dropping a command.
REQ-003 Parameter RST_MIN, default 16: minimum clk cycles that snd_rstb stays low.
REQ-004 clk  in  1  system clock (48 MHz).
REQ-005 rst  in  1  reset; one clock, synchronous and active-high.
REQ-006 cpu_cen  in  1  main CPU clock enable; write strobes count only on cycles where it is high.
REQ-007 cpu_dout  in  8  main CPU write data.
REQ-008 cmd_we  in  1  main CPU write to the sound command register.
REQ-009 rstctl_we  in  1  main CPU write to the sound reset register; only bit 0 is used.
REQ-010 snd_ack  in  1  sound CPU latch-read select, level signal, possibly several cycles wide.
REQ-011 snd_latch  out  8  command byte presented to the sound CPU.
REQ-012 snd_irq  out  1  command strobe; the sound side triggers on its rising edge.
REQ-013 snd_rstb  out  1  sound CPU reset, active low.
REQ-014 busy  out  1  high while the FIFO is non-empty or state is not IDLE.
REQ-015 full  out  1  high while the FIFO holds 4 entries.
REQ-016 level  out  3  FIFO occupancy, 0-4.
REQ-017 ovf  out  1  sticky flag: a command was lost to overflow or to ack timeout.

Function
REQ-018 The block SHALL hold a 4-entry FIFO; a write is accepted when cmd_we and cpu_cen are both high.
REQ-019 A write while full SHALL be discarded; the cycle SHALL set ovf; FIFO contents and level SHALL not change.
REQ-020 A push and a pop in the same cycle SHALL both take effect; level SHALL stay unchanged.
REQ-021 A push while full with a simultaneous pop SHALL be accepted, with no ovf.
REQ-022 Pointers SHALL wrap modulo 4.
REQ-023 States: IDLE, PULSE, WAIT.
REQ-024 IDLE with FIFO non-empty: in that cycle, pop the head into snd_latch and go to PULSE.
REQ-025 The snd_irq timing SHALL be as follows:
- snd_irq rises one cycle after the pop.
- snd_irq stays high for exactly IRQ_W cycles.
- snd_irq is low in all other states.
REQ-026 snd_latch SHALL be stable from the pop until the next pop.
REQ-027 The block SHALL edge-detect snd_ack with a registered previous value; only rising edges count.
REQ-028 An ack rising edge during PULSE SHALL be remembered; when the pulse ends, go directly to IDLE.
REQ-029 End of PULSE with no ack seen: go to WAIT and clear the timeout counter.
REQ-030 WAIT behaviour:
- An ack rising edge goes to IDLE.
- After ACK_TO cycles with no ack, set ovf and go to IDLE, so the next command proceeds.
REQ-031 Ack edges seen in IDLE SHALL be ignored.
REQ-032 Minimum spacing between successive snd_irq rising edges is IRQ_W+2 cycles.
REQ-033 Writing bit 0 = 0 on the reset register (rstctl_we with cpu_cen) SHALL:
- drive snd_rstb low;
- flush the FIFO (level = 0);
- force IDLE and drive snd_irq low;
- clear ovf;
- preserve snd_latch.
REQ-034 Writing bit 0 = 1 SHALL release snd_rstb; the release takes effect only once snd_rstb has been low for at least RST_MIN cycles; an early release is held pending and applied at RST_MIN.
REQ-035 While snd_rstb is low, command writes SHALL be accepted into the FIFO but SHALL not be popped.
REQ-036 If cmd_we and rstctl_we(0) occur in the same cycle, the flush SHALL win and the command SHALL be dropped, without setting ovf.
REQ-037 busy and full SHALL be combinational from registered state, with zero-cycle latency after the update.

Reset
REQ-038 rst SHALL set:
- snd_latch = 0x00;
- snd_irq = 0;
- snd_rstb = 0, with the RST_MIN counter started;
- level = 0, full = 0, busy = 0, ovf = 0;
- state = IDLE, with the timeout counter and ack history cleared.
REQ-039 After rst, snd_rstb SHALL rise by itself after RST_MIN cycles; no register write is needed.
REQ-040 rst asserted mid-PULSE or mid-WAIT SHALL abort the command and drop snd_irq the next cycle.

Verification
REQ-041 Single command: rst, wait 16 cycles, write 0x3C, with snd_ack pulsed 20 cycles later.
- snd_latch = 0x3C one cycle after the write.
- snd_irq is high for exactly 8 cycles.
- busy falls on the cycle after the ack edge.
REQ-042 Burst with full and overflow: with snd_ack held low, write 0x01 through 0x06 back-to-back.
- The first write pops immediately; level reaches 4 and full = 1.
- The 6th write sets ovf.
- Then ack each command: the sequence 01, 02, 03, 04, 05 appears on snd_latch; 06 never appears.
REQ-043 Timeout: write 0xAA and 0xBB, never ack.
- After 8 + 4096 cycles, ovf = 1 and snd_latch = 0xBB with a new snd_irq rising edge.
REQ-044 Reset control: with 3 entries queued, write rstctl 0, then rstctl 1 two cycles later.
- level = 0 and snd_irq = 0.
- snd_rstb stays low for exactly 16 cycles.
- No snd_irq rising edge occurs until a new write.
REQ-045 Simultaneous events, both of which must hold:
- Push and pop in the same cycle while full: level stays at 4 and ovf = 0.
- Ack asserted during PULSE: no WAIT state is entered, and the next snd_irq rising edge occurs exactly 10 cycles after the previous one.
